seg_display_arbiter: RTL and testbench

- Shares the single 8-digit seven-segment display between three display sources: alarm, revenue screen, and mode/status screen.
- Arbitrates at frame boundaries.
- Inserts one blank frame whenever it switches between sources.
- Lets the alarm source preempt the others at the next digit boundary.
- Owns the scan divider and the digit multiplexing, and drives the active-low seg_en/seg_out pins directly.

---
 rtl/seg_display_arbiter.sv | 163 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit active-low seven-segment display between an alarm source and two
// round-robin peers, with frame-boundary arbitration, blank frames on source changes and alarm preemption.
module seg_display_arbiter #(
    parameter int SCAN_DIV    = 25000,
    parameter int HOLD_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
    input  logic [63:0] data2,
    output logic [2:0]  grant,
    output logic        frame_done,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam logic [31:0] CNT_LAST    = 32'(SCAN_DIV - 1);
    localparam logic [8:0]  HOLD_LIMIT  = 9'(HOLD_FRAMES);
    localparam logic [1:0]  TARGET_NONE = 2'd3;

    logic [31:0] cnt;
    logic [2:0]  scan;
    state_t      state, state_nx;
    logic [2:0]  grant_nx;
    logic [7:0]  hold_cnt, hold_nx, hold_sat;
    logic [8:0]  hold_plus;
    logic [1:0]  target, target_nx;
    logic [1:0]  rr_last, rr_nx;
    logic        tick, frame_end;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        peer_req;
    logic [1:0]  peer_idx;
    logic        rotate_due;
    logic [63:0] data_g;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (scan == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            scan <= '0;
        end else if (tick) begin
            cnt  <= '0;
            scan <= scan + 3'd1;
        end else begin
            cnt  <= cnt + 32'd1;
        end
    end

    // Alarm wins outright; the peers alternate, skipping whichever was shown last.
    always_comb begin
        sel_valid = |req;
        sel_idx   = 2'd2;
        if (req[0])
            sel_idx = 2'd0;
        else if (req[1] && req[2])
            sel_idx = (rr_last == 2'd1) ? 2'd2 : 2'd1;
        else if (req[1])
            sel_idx = 2'd1;
    end

    assign peer_req   = grant[1] ? req[2] : req[1];
    assign peer_idx   = grant[1] ? 2'd2 : 2'd1;
    assign hold_plus  = {1'b0, hold_cnt} + 9'd1;
    assign rotate_due = (hold_plus >= HOLD_LIMIT);
    assign hold_sat   = ({1'b0, hold_cnt} >= HOLD_LIMIT) ? hold_cnt : hold_cnt + 8'd1;

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        hold_nx   = hold_cnt;
        target_nx = target;
        rr_nx     = rr_last;
        // Preemption is checked on every digit step and overrides any frame-end decision.
        if (tick && req[0] && ((state == SHOW && !grant[0]) || state == BLANK)) begin
            state_nx  = SHOW;
            grant_nx  = 3'b001;
            hold_nx   = '0;
            target_nx = TARGET_NONE;
        end else if (frame_end) begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state_nx = SHOW;
                        grant_nx = 3'b001 << sel_idx;
                        hold_nx  = '0;
                        if (sel_idx != 2'd0)
                            rr_nx = sel_idx;
                    end
                end
                SHOW: begin
                    hold_nx = hold_sat;
                    if ((req & grant) == 3'b000) begin
                        grant_nx = 3'b000;
                        if (!sel_valid) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx  = BLANK;
                            target_nx = sel_idx;
                        end
                    end else if (!grant[0] && peer_req && rotate_due) begin
                        state_nx  = BLANK;
                        grant_nx  = 3'b000;
                        target_nx = peer_idx;
                    end
                end
                BLANK: begin
                    target_nx = TARGET_NONE;
                    if (!sel_valid) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = SHOW;
                        grant_nx = 3'b001 << sel_idx;
                        hold_nx  = '0;
                        if (sel_idx != 2'd0)
                            rr_nx = sel_idx;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    grant_nx = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 3'b000;
            hold_cnt <= '0;
            target   <= TARGET_NONE;
            rr_last  <= 2'd2;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            hold_cnt <= hold_nx;
            target   <= target_nx;
            rr_last  <= rr_nx;
        end
    end

    always_comb begin
        data_g = '0;
        if (grant[0])
            data_g = data0;
        else if (grant[1])
            data_g = data1;
        else if (grant[2])
            data_g = data2;
    end

    assign frame_done = frame_end;
    assign seg_en     = ~(8'b0000_0001 << scan);
    assign seg_out    = (state == SHOW) ? ~data_g[{scan, 3'b000} +: 8] : 8'hFF;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (SCAN_DIV=4, HOLD_FRAMES=2): expectations are queued
// with the stimulus that causes them and compared on the falling edge of the cycle they name.
module tb_seg_display_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [63:0] data0, data1, data2;
    logic [2:0]  grant;
    logic        frame_done;
    logic [7:0]  seg_en, seg_out;

    typedef struct {
        int          k;
        string       tag;
        logic [19:0] val;
    } exp_t;

    exp_t sb[$];
    int   k;
    int   tests;
    int   fails;

    seg_display_arbiter #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .grant      (grant),
        .frame_done (frame_done),
        .seg_en     (seg_en),
        .seg_out    (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expect(input int kk, input string tag, input logic [2:0] g,
                               input logic fd, input logic [7:0] en, input logic [7:0] so);
        exp_t e;
        e.k   = kk;
        e.tag = tag;
        e.val = {g, fd, en, so};
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [19:0] obs;
        while (sb.size() > 0 && sb[0].k <= k) begin
            e   = sb.pop_front();
            obs = {grant, frame_done, seg_en, seg_out};
            tests++;
            assert (obs === e.val && e.k == k) else begin
                fails++;
                $error("FAIL %s k=%0d observed grant=%b fd=%b en=%h out=%h expected(k=%0d) grant=%b fd=%b en=%h out=%h",
                       e.tag, k, obs[19:17], obs[16], obs[15:8], obs[7:0],
                       e.k, e.val[19:17], e.val[16], e.val[15:8], e.val[7:0]);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r);
        req = r;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        k     = -1;
        rst   = 1'b1;
        req   = 3'b000;
        data0 = 64'h4746454443424140;
        data1 = 64'h0807060504030201;
        data2 = 64'h1716151413121110;

        // reset state, then idle scanning
        @(negedge clk);
        @(negedge clk);
        push_expect(k, "reset", 3'b000, 1'b0, 8'hFE, 8'hFF);
        checkOutput();
        rst = 1'b0;
        k   = 0;
        push_expect(0,  "p1_k0",    3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(3,  "p1_k3",    3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(4,  "p1_scan1", 3'b000, 1'b0, 8'hFD, 8'hFF);
        push_expect(30, "p1_scan7", 3'b000, 1'b0, 8'h7F, 8'hFF);
        push_expect(31, "p1_fd",    3'b000, 1'b1, 8'h7F, 8'hFF);
        push_expect(32, "p1_wrap",  3'b000, 1'b0, 8'hFE, 8'hFF);
        checkOutput();
        run_to(32);

        // single peer request, granted at the next frame end without a blank frame
        applyStimulus(3'b010);
        push_expect(63, "p2_pre",   3'b000, 1'b1, 8'h7F, 8'hFF);
        push_expect(64, "p2_grant", 3'b010, 1'b0, 8'hFE, 8'hFE);
        push_expect(76, "p2_d3",    3'b010, 1'b0, 8'hF7, 8'hFB);
        run_to(77);
        data1 = 64'h0807060580030201;
        #1;
        push_expect(k, "p2_live_data", 3'b010, 1'b0, 8'hF7, 8'h7F);
        checkOutput();
        data1 = 64'h0807060504030201;

        // both peers: rotation with blank frames between them
        run_to(78);
        applyStimulus(3'b110);
        push_expect(100, "p3_src1",      3'b010, 1'b0, 8'hFD, 8'hFD);
        push_expect(127, "p3_src1_end",  3'b010, 1'b1, 8'h7F, 8'hF7);
        push_expect(128, "p3_blank",     3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(150, "p3_blank_mid", 3'b000, 1'b0, 8'hDF, 8'hFF);
        push_expect(159, "p3_blank_end", 3'b000, 1'b1, 8'h7F, 8'hFF);
        push_expect(160, "p3_src2",      3'b100, 1'b0, 8'hFE, 8'hEF);
        push_expect(200, "p3_src2_mid",  3'b100, 1'b0, 8'hFB, 8'hED);
        push_expect(223, "p3_src2_end",  3'b100, 1'b1, 8'h7F, 8'hE8);
        push_expect(224, "p3_blank2",    3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(256, "p3_src1_again",3'b010, 1'b0, 8'hFE, 8'hFE);
        push_expect(352, "p3_src2_again",3'b100, 1'b0, 8'hFE, 8'hEF);
        run_to(364);

        // alarm preempts source 2 at scan 3, then drops mid-frame
        applyStimulus(3'b111);
        push_expect(367, "p4_before_tick", 3'b100, 1'b0, 8'hF7, 8'hEC);
        push_expect(368, "p4_preempt",     3'b001, 1'b0, 8'hEF, 8'hBB);
        run_to(372);
        applyStimulus(3'b110);
        push_expect(383, "p4_alarm_end",   3'b001, 1'b1, 8'h7F, 8'hB8);
        push_expect(384, "p4_blank",       3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(415, "p4_blank_end",   3'b000, 1'b1, 8'h7F, 8'hFF);
        push_expect(416, "p4_rr_src1",     3'b010, 1'b0, 8'hFE, 8'hFE);
        run_to(420);

        // source 2 alone, dropped mid-frame, then reasserted from idle
        applyStimulus(3'b100);
        push_expect(447, "p5_src1_end",  3'b010, 1'b1, 8'h7F, 8'hF7);
        push_expect(448, "p5_blank",     3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(480, "p5_src2",      3'b100, 1'b0, 8'hFE, 8'hEF);
        run_to(490);
        applyStimulus(3'b000);
        push_expect(500, "p5_hold",      3'b100, 1'b0, 8'hDF, 8'hEA);
        push_expect(511, "p5_last",      3'b100, 1'b1, 8'h7F, 8'hE8);
        push_expect(512, "p5_idle",      3'b000, 1'b0, 8'hFE, 8'hFF);
        run_to(520);
        applyStimulus(3'b100);
        push_expect(543, "p5_idle_end",  3'b000, 1'b1, 8'h7F, 8'hFF);
        push_expect(544, "p5_reshow",    3'b100, 1'b0, 8'hFE, 8'hEF);
        push_expect(564, "p5_scan5",     3'b100, 1'b0, 8'hDF, 8'hEA);
        run_to(564);

        // asynchronous reset mid-frame, counting restarts from zero
        rst = 1'b1;
        #1;
        push_expect(k, "p6_rst_async", 3'b000, 1'b0, 8'hFE, 8'hFF);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        push_expect(0,  "p6_k0",    3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(3,  "p6_k3",    3'b000, 1'b0, 8'hFE, 8'hFF);
        push_expect(4,  "p6_k4",    3'b000, 1'b0, 8'hFD, 8'hFF);
        push_expect(31, "p6_fd",    3'b000, 1'b1, 8'h7F, 8'hFF);
        push_expect(32, "p6_show",  3'b100, 1'b0, 8'hFE, 8'hEF);
        checkOutput();
        run_to(32);

        // all requests together from idle pick the alarm; alarm also preempts a blank frame
        applyStimulus(3'b000);
        push_expect(64, "p7_idle", 3'b000, 1'b0, 8'hFE, 8'hFF);
        run_to(70);
        applyStimulus(3'b111);
        push_expect(96, "p7_all_alarm", 3'b001, 1'b0, 8'hFE, 8'hBF);
        run_to(100);
        applyStimulus(3'b110);
        push_expect(128, "p7_blank", 3'b000, 1'b0, 8'hFE, 8'hFF);
        run_to(136);
        applyStimulus(3'b111);
        push_expect(139, "p7_blank_pre",     3'b000, 1'b0, 8'hFB, 8'hFF);
        push_expect(140, "p7_blank_preempt", 3'b001, 1'b0, 8'hF7, 8'hBC);
        run_to(140);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
